power_seq_ctrl: RTL and testbench

Parametrised per-peripheral power sequencer for the SoC low-power subsystem. It is the successor to the 3-state ACTIVE/IDLE/SLEEP controller and adds three behaviours:
- programmable dwell timers before each power-down step;
- a WAKING state with a clock-acknowledge handshake to the clock-gating unit;
- wake-timeout error reporting.

It sits between the peripheral activity monitors and the clock-gate/PMU block, with N independent channels sharing one clock.

---
 rtl/power_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_power_seq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/power_seq_ctrl.sv
// power_seq_ctrl: per-peripheral power sequencer with N independent channels.
// Each channel steps ACTIVE -> IDLE -> SLEEP after programmable dwell counts,
// wakes through a WAKING state that waits for the clock-gating unit's
// acknowledge, and reports handshake completion or timeout as 1-cycle pulses.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   sleep_eligible[N]   per-channel request to step down power
//   wake_evt[N]         per-channel wake event
//   periph_en[N]        per-channel enable; 0 forces SLEEP
//   clk_ack[N]          clock-running acknowledge (only used in WAKING)
//   idle_thresh         ACTIVE dwell before IDLE, minus one (shared)
//   sleep_thresh        IDLE dwell before SLEEP, minus one (shared)
//   ack_timeout         WAKING cycles allowed without clk_ack, minus one
//   state[N][2]         ACTIVE=00 IDLE=01 SLEEP=10 WAKING=11
//   clk_req[N]          clock request, combinational
//   wake_done[N]        registered pulse, handshake completed
//   wake_err[N]         registered pulse, handshake timed out
//   all_asleep          every channel in SLEEP, combinational

// One sequencer channel.
module power_seq_chan #(
   parameter int TW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sleep_eligible,
   input  logic          wake_evt,
   input  logic          periph_en,
   input  logic          clk_ack,
   input  logic [TW-1:0] idle_thresh,
   input  logic [TW-1:0] sleep_thresh,
   input  logic [TW-1:0] ack_timeout,
   output logic [1:0]    state,
   output logic          wake_done,
   output logic          wake_err
);
   typedef enum logic [1:0] {
      ACTIVE = 2'b00,
      IDLE   = 2'b01,
      SLEEP  = 2'b10,
      WAKING = 2'b11
   } st_t;

   st_t           st, nxt_st;
   logic [TW-1:0] cnt, nxt_cnt, cnt_inc;
   logic          nxt_done, nxt_err;

   // Saturating increment: cnt cannot legitimately exceed threshold+1, but
   // hold at all-ones rather than wrap if that ever fails to hold.
   assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= ACTIVE;
         cnt       <= '0;
         wake_done <= 1'b0;
         wake_err  <= 1'b0;
      end else begin
         st        <= nxt_st;
         cnt       <= nxt_cnt;
         wake_done <= nxt_done;
         wake_err  <= nxt_err;
      end
   end

   always_comb begin
      nxt_st   = st;
      nxt_cnt  = cnt;
      nxt_done = 1'b0;
      nxt_err  = 1'b0;
      if (!periph_en) begin
         nxt_st  = SLEEP;
         nxt_cnt = '0;
      end else begin
         unique case (st)
            ACTIVE: begin
               if (wake_evt) begin
                  nxt_cnt = '0;
               end else if (sleep_eligible && cnt >= idle_thresh) begin
                  nxt_st  = IDLE;
                  nxt_cnt = '0;
               end else if (sleep_eligible) begin
                  nxt_cnt = cnt_inc;
               end else begin
                  nxt_cnt = '0;
               end
            end
            IDLE: begin
               if (wake_evt || !sleep_eligible) begin
                  nxt_st  = ACTIVE;
                  nxt_cnt = '0;
               end else if (cnt >= sleep_thresh) begin
                  nxt_st  = SLEEP;
                  nxt_cnt = '0;
               end else begin
                  nxt_cnt = cnt_inc;
               end
            end
            SLEEP: begin
               if (wake_evt) begin
                  nxt_st  = WAKING;
                  nxt_cnt = '0;
               end
            end
            WAKING: begin
               // Acknowledge wins over a coincident timeout.
               if (clk_ack) begin
                  nxt_st   = ACTIVE;
                  nxt_cnt  = '0;
                  nxt_done = 1'b1;
               end else if (cnt >= ack_timeout) begin
                  nxt_st  = SLEEP;
                  nxt_cnt = '0;
                  nxt_err = 1'b1;
               end else begin
                  nxt_cnt = cnt_inc;
               end
            end
            default: begin
               nxt_st  = ACTIVE;
               nxt_cnt = '0;
            end
         endcase
      end
   end

   assign state = st;
endmodule

module power_seq_ctrl #(
   parameter int N  = 4,
   parameter int TW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      sleep_eligible,
   input  logic [N-1:0]      wake_evt,
   input  logic [N-1:0]      periph_en,
   input  logic [N-1:0]      clk_ack,
   input  logic [TW-1:0]     idle_thresh,
   input  logic [TW-1:0]     sleep_thresh,
   input  logic [TW-1:0]     ack_timeout,
   output logic [N-1:0][1:0] state,
   output logic [N-1:0]      clk_req,
   output logic [N-1:0]      wake_done,
   output logic [N-1:0]      wake_err,
   output logic              all_asleep
);
   logic [N-1:0] is_sleep;

   for (genvar i = 0; i < N; i++) begin : g_chan
      power_seq_chan #(.TW(TW)) u_chan (
         .clk            (clk),
         .rst            (rst),
         .sleep_eligible (sleep_eligible[i]),
         .wake_evt       (wake_evt[i]),
         .periph_en      (periph_en[i]),
         .clk_ack        (clk_ack[i]),
         .idle_thresh    (idle_thresh),
         .sleep_thresh   (sleep_thresh),
         .ack_timeout    (ack_timeout),
         .state          (state[i]),
         .wake_done      (wake_done[i]),
         .wake_err       (wake_err[i])
      );
      assign is_sleep[i] = (state[i] == 2'b10);
      assign clk_req[i]  = periph_en[i] & ~is_sleep[i];
   end

   assign all_asleep = &is_sleep;
endmodule

// File: tb/tb_power_seq_ctrl.sv
module tb_power_seq_ctrl;
   localparam int N  = 4;
   localparam int TW = 8;
   localparam logic [1:0] ACT = 2'b00, IDL = 2'b01, SLP = 2'b10, WAK = 2'b11;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      sleep_eligible, wake_evt, periph_en, clk_ack;
   logic [TW-1:0]     idle_thresh, sleep_thresh, ack_timeout;
   logic [N-1:0][1:0] state;
   logic [N-1:0]      clk_req, wake_done, wake_err;
   logic              all_asleep;

   int total = 0;
   int bad   = 0;

   power_seq_ctrl #(.N(N), .TW(TW)) dut (
      .clk            (clk),
      .rst            (rst),
      .sleep_eligible (sleep_eligible),
      .wake_evt       (wake_evt),
      .periph_en      (periph_en),
      .clk_ack        (clk_ack),
      .idle_thresh    (idle_thresh),
      .sleep_thresh   (sleep_thresh),
      .ack_timeout    (ack_timeout),
      .state          (state),
      .clk_req        (clk_req),
      .wake_done      (wake_done),
      .wake_err       (wake_err),
      .all_asleep     (all_asleep)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; periph_en = 4'hF; sleep_eligible = '0; wake_evt = '0; clk_ack = '0;
      idle_thresh = 8'd3; sleep_thresh = 8'd2; ack_timeout = 8'd5;
      tick();
      chk("rst_state", state, 8'h00);
      chk("rst_done", wake_done, 4'h0);
      chk("rst_err", wake_err, 4'h0);
      chk("rst_clkreq", clk_req, 4'hF);
      chk("rst_asleep", all_asleep, 1'b0);
      rst = 1'b0;

      // ch0 dwell: IDLE after 4th edge, SLEEP after 7th
      sleep_eligible = 4'b0001;
      tick(3);
      chk("c0_act3", state[0], ACT);
      tick();
      chk("c0_idle4", state[0], IDL);
      tick(2);
      chk("c0_idle6", state[0], IDL);
      chk("c0_req6", clk_req[0], 1'b1);
      tick();
      chk("c0_sleep7", state[0], SLP);
      chk("c0_req7", clk_req[0], 1'b0);
      chk("others_act", state[3:1], 6'h00);
      sleep_eligible = '0;

      // ch1: force SLEEP, wake, ack after 2 WAKING cycles
      periph_en = 4'b1101;
      tick();
      chk("c1_forced", state[1], SLP);
      periph_en = 4'hF;
      clk_ack = 4'b0001;               // ch0 SLEEP must ignore ack
      tick();
      chk("c1_stay", state[1], SLP);
      chk("c0_ack_ign", state[0], SLP);
      chk("c1_req_off", clk_req[1], 1'b0);
      clk_ack = '0;
      wake_evt = 4'b0010;
      tick();
      chk("c1_waking", state[1], WAK);
      chk("c1_req_on", clk_req[1], 1'b1);
      wake_evt = '0;
      tick(2);
      chk("c1_wak3", state[1], WAK);
      clk_ack = 4'b0010;
      tick();
      chk("c1_active", state[1], ACT);
      chk("c1_done", wake_done, 4'b0010);
      chk("c1_noerr", wake_err, 4'h0);
      clk_ack = '0;
      tick();
      chk("c1_done_end", wake_done, 4'h0);

      // ch1 timeout: 6 WAKING cycles then SLEEP with wake_err
      periph_en = 4'b1101;
      tick();
      periph_en = 4'hF;
      wake_evt = 4'b0010;
      tick();
      wake_evt = '0;
      tick(5);
      chk("c1_wak6", state[1], WAK);
      tick();
      chk("c1_tmo", state[1], SLP);
      chk("c1_err", wake_err, 4'b0010);
      chk("c1_err_nodone", wake_done, 4'h0);
      chk("c1_tmo_req", clk_req[1], 1'b0);
      tick();
      chk("c1_err_end", wake_err, 4'h0);

      // ch2: drop enable in WAKING
      periph_en = 4'b1011;
      tick();
      periph_en = 4'hF;
      wake_evt = 4'b0100;
      tick();
      chk("c2_waking", state[2], WAK);
      wake_evt = '0;
      periph_en = 4'b1011;
      clk_ack = 4'b0100;               // enable drop outranks ack
      tick();
      chk("c2_en_wak", state[2], SLP);
      chk("c2_en_wak_p", {wake_done, wake_err}, 8'h00);
      clk_ack = '0;
      periph_en = 4'hF;
      // ch2: back to ACTIVE, count to 2, drop enable
      wake_evt = 4'b0100;
      tick();
      wake_evt = '0;
      clk_ack = 4'b0100;
      tick();
      chk("c2_active", state[2], ACT);
      clk_ack = '0;
      sleep_eligible = 4'b0100;
      tick(2);
      periph_en = 4'b1011;
      tick();
      chk("c2_en_act", state[2], SLP);
      chk("c2_en_act_p", {wake_done, wake_err}, 8'h00);
      chk("asleep_0", all_asleep, 1'b0);
      sleep_eligible = '0;
      periph_en = 4'b0011;
      tick();
      chk("asleep_1", all_asleep, 1'b1);
      periph_en = 4'hF;
      tick();
      chk("asleep_hold", all_asleep, 1'b1);

      // ch3: wake, then eligibility pattern 1,1,0,1,1,1,1
      wake_evt = 4'b1000;
      tick();
      wake_evt = '0;
      clk_ack = 4'b1000;
      tick();
      clk_ack = '0;
      chk("c3_active", state[3], ACT);
      sleep_eligible = 4'b1000; tick(2);
      sleep_eligible = 4'b0000; tick();
      sleep_eligible = 4'b1000; tick(3);
      chk("c3_not_idle", state[3], ACT);
      tick();
      chk("c3_idle", state[3], IDL);
      wake_evt = 4'b1000;
      tick();
      chk("c3_wake_ret", state[3], ACT);
      wake_evt = '0;
      tick(4);
      chk("c3_idle2", state[3], IDL);
      sleep_eligible = '0;
      tick();
      chk("c3_elig_ret", state[3], ACT);

      // ch1 reset mid-WAKING with ack present
      wake_evt = 4'b0010;
      tick();
      chk("c1_wak_rst", state[1], WAK);
      wake_evt = '0;
      clk_ack = 4'b0010;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clk_ack = '0;
      chk("rst2_state", state, 8'h00);
      chk("rst2_pulses", {wake_done, wake_err}, 8'h00);
      tick();
      chk("rst2_nopulse", {wake_done, wake_err}, 8'h00);

      // zero thresholds: one eligible cycle per step
      idle_thresh = 8'd0; sleep_thresh = 8'd0;
      sleep_eligible = 4'b0001;
      tick();
      chk("z_idle", state[0], IDL);
      tick();
      chk("z_sleep", state[0], SLP);

      // lowering threshold below cnt fires on next edge
      idle_thresh = 8'd9;
      sleep_eligible = 4'b0010;
      tick(3);
      chk("lo_act", state[1], ACT);
      idle_thresh = 8'd1;
      tick();
      chk("lo_idle", state[1], IDL);
      sleep_eligible = '0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
